// File: rtl/lsu_rmw_ctrl.sv
// Load/store sequencer in front of a word-only data memory: sub-word stores inside
// the data region become a two-cycle read-modify-write; loads are extracted and extended.
module lsu_rmw_ctrl #(
  parameter logic [15:0] DMEM_BASE  = 16'h2000,
  parameter logic [15:0] DMEM_LIMIT = 16'h3FFF,
  parameter int          CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic             i_wren,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_wdata,
  input  logic [2:0]       i_lsu_op,
  output logic [31:0]      o_rdata,
  output logic             o_stall,
  output logic             o_done,
  output logic             o_misaligned,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic             o_mem_wren,
  input  logic [31:0]      i_mem_rdata,
  output logic [CNT_W-1:0] o_rmw_cnt,
  output logic             o_dbg_rmw
);

  // Handshake: i_req is a level request held while o_stall=1; o_done marks the
  // cycle in which the access (or its rejection) completes.
  typedef enum logic {S_IDLE, S_RMW_WR} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      merge_q, merge_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        is_b, is_h, is_w, is_unsigned;
  logic        misaligned, in_region;
  logic [31:0] aligned_addr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  always_comb begin
    is_b         = (i_lsu_op == 3'b000) || (i_lsu_op == 3'b100);
    is_h         = (i_lsu_op == 3'b001) || (i_lsu_op == 3'b101);
    is_w         = !is_b && !is_h;
    is_unsigned  = i_lsu_op[2];
    aligned_addr = {i_addr[31:2], 2'b00};
    misaligned   = (is_h && i_addr[0]) || (is_w && (i_addr[1:0] != 2'b00));
    in_region    = (i_addr[15:0] >= DMEM_BASE) && (i_addr[15:0] <= DMEM_LIMIT);
  end

  // Lane extraction for loads and lane insertion for the merge word.
  always_comb begin
    ld_byte = 8'h00;
    merged  = i_mem_rdata;
    case (i_addr[1:0])
      2'b00: ld_byte = i_mem_rdata[7:0];
      2'b01: ld_byte = i_mem_rdata[15:8];
      2'b10: ld_byte = i_mem_rdata[23:16];
      default: ld_byte = i_mem_rdata[31:24];
    endcase
    ld_half = i_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    if (is_b)
      ld_ext = is_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    else if (is_h)
      ld_ext = is_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
    else
      ld_ext = i_mem_rdata;
    if (is_b) begin
      case (i_addr[1:0])
        2'b00: merged[7:0]   = i_wdata[7:0];
        2'b01: merged[15:8]  = i_wdata[7:0];
        2'b10: merged[23:16] = i_wdata[7:0];
        default: merged[31:24] = i_wdata[7:0];
      endcase
    end else if (i_addr[1]) begin
      merged[31:16] = i_wdata[15:0];
    end else begin
      merged[15:0] = i_wdata[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    merge_d      = merge_q;
    cnt_d        = cnt_q;
    o_rdata      = 32'h0;
    o_stall      = 1'b0;
    o_done       = 1'b0;
    o_misaligned = 1'b0;
    o_mem_addr   = 32'h0;
    o_mem_wdata  = 32'h0;
    o_mem_wren   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          o_mem_addr = aligned_addr;
          if (misaligned) begin
            o_misaligned = 1'b1;
            o_done       = 1'b1;
          end else if (!i_wren) begin
            o_rdata = ld_ext;
            o_done  = 1'b1;
          end else if (is_w || !in_region) begin
            // Peripherals see the raw word, sub-word stores included.
            o_mem_wren  = 1'b1;
            o_mem_wdata = i_wdata;
            o_done      = 1'b1;
          end else begin
            o_stall = 1'b1;
            addr_d  = aligned_addr;
            merge_d = merged;
            state_d = S_RMW_WR;
          end
        end
      end
      S_RMW_WR: begin
        // Committed write: inputs are ignored, the core advances on this edge.
        o_mem_addr  = addr_q;
        o_mem_wdata = merge_q;
        o_mem_wren  = 1'b1;
        o_done      = 1'b1;
        cnt_d       = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      merge_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      merge_q <= merge_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_rmw_cnt = cnt_q;
  assign o_dbg_rmw = (state_q == S_RMW_WR);

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Directed bench for lsu_rmw_ctrl with a small word memory model (async read, sync write).
module tb_lsu_rmw_ctrl;

  localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010,
                         OP_BU = 3'b100, OP_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wren;
  logic [31:0] addr, wdata;
  logic [2:0]  lsu_op;
  logic [31:0] rdata;
  logic        stall, done, misal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wren;
  logic [15:0] rmw_cnt;
  logic        dbg_rmw;

  logic [31:0] mem [16];
  logic        mem_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_rmw_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wren(wren), .i_addr(addr),
    .i_wdata(wdata), .i_lsu_op(lsu_op), .o_rdata(rdata), .o_stall(stall),
    .o_done(done), .o_misaligned(misal), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata),
    .o_rmw_cnt(rmw_cnt), .o_dbg_rmw(dbg_rmw)
  );

  function automatic logic [3:0] midx(input logic [31:0] a);
    return {a[12], a[4:2]};
  endfunction

  assign mem_rdata = mem[midx(mem_addr)];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (mem_wren) begin
      mem[midx(mem_addr)] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive a request and move to the middle of the cycle for checking.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] op);
    req = 1'b1; wren = w; addr = a; wdata = d; lsu_op = op;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 1'b0; wren = 1'b0; addr = 32'h0; wdata = 32'h0; lsu_op = OP_W;
  endtask

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1;
    idle();
    @(negedge clk);
    check("rst_done", 32'(done), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_wren", 32'(mem_wren), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_cnt", 32'(rmw_cnt), 32'h0);
    check("rst_state", 32'(dbg_rmw), 32'h0);
    tick(); tick();
    rst_n = 1'b1; mem_clr = 1'b0;

    // Preload and byte/half loads
    access(1'b1, 32'h2004, 32'h11223344, OP_W);
    check("sw_pre_wren", 32'(mem_wren), 32'h1);
    check("sw_pre_stall", 32'(stall), 32'h0);
    tick();
    access(1'b0, 32'h2007, 32'h0, OP_B);
    check("lb7_rdata", rdata, 32'h00000011);
    check("lb7_done", 32'(done), 32'h1);
    check("lb7_stall", 32'(stall), 32'h0);
    check("lb7_maddr", mem_addr, 32'h00002004);
    tick();
    access(1'b1, 32'h2004, 32'h11228044, OP_W);
    tick();
    access(1'b0, 32'h2005, 32'h0, OP_BU);
    check("lbu5", rdata, 32'h00000080);
    tick();
    access(1'b0, 32'h2005, 32'h0, OP_B);
    check("lb5", rdata, 32'hFFFFFF80);
    tick();
    access(1'b0, 32'h2004, 32'h0, OP_H);
    check("lh4", rdata, 32'hFFFF8044);
    tick();
    access(1'b0, 32'h2004, 32'h0, OP_HU);
    check("lhu4", rdata, 32'h00008044);
    tick();
    access(1'b0, 32'h2006, 32'h0, OP_H);
    check("lh6", rdata, 32'h00001122);
    tick();
    access(1'b0, 32'h2004, 32'h0, 3'b111);
    check("lw_oddop", rdata, 32'h11228044);
    tick();
    access(1'b1, 32'h2004, 32'h11223344, OP_W);
    tick();

    // SB RMW
    access(1'b1, 32'h2006, 32'h000000AB, OP_B);
    check("sb_c1_stall", 32'(stall), 32'h1);
    check("sb_c1_wren", 32'(mem_wren), 32'h0);
    check("sb_c1_done", 32'(done), 32'h0);
    check("sb_c1_maddr", mem_addr, 32'h00002004);
    tick();
    @(negedge clk);
    check("sb_c2_wren", 32'(mem_wren), 32'h1);
    check("sb_c2_maddr", mem_addr, 32'h00002004);
    check("sb_c2_wdata", mem_wdata, 32'h11AB3344);
    check("sb_c2_done", 32'(done), 32'h1);
    check("sb_c2_stall", 32'(stall), 32'h0);
    check("sb_c2_state", 32'(dbg_rmw), 32'h1);
    tick();
    idle();
    check("sb_cnt", 32'(rmw_cnt), 32'h1);
    check("sb_state_back", 32'(dbg_rmw), 32'h0);
    access(1'b0, 32'h2004, 32'h0, OP_W);
    check("sb_readback", rdata, 32'h11AB3344);
    tick();

    // SH then back-to-back SB into the same word
    access(1'b1, 32'h2002, 32'h0000BEEF, OP_H);
    check("sh_c1_stall", 32'(stall), 32'h1);
    tick();
    @(negedge clk);
    check("sh_c2_wdata", mem_wdata, 32'hBEEF0000);
    tick();
    access(1'b1, 32'h2001, 32'h00000055, OP_B);
    check("sb2_c1_stall", 32'(stall), 32'h1);
    tick();
    @(negedge clk);
    check("sb2_c2_wdata", mem_wdata, 32'hBEEF5500);
    check("sb2_c2_maddr", mem_addr, 32'h00002000);
    tick();
    idle();
    check("b2b_cnt", 32'(rmw_cnt), 32'h3);
    access(1'b0, 32'h2000, 32'h0, OP_W);
    check("b2b_readback", rdata, 32'hBEEF5500);
    tick();

    // Outside the region: single-cycle full-word writes
    access(1'b1, 32'h7000, 32'hDEADBEEF, OP_W);
    check("sw7_wren", 32'(mem_wren), 32'h1);
    check("sw7_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw7_maddr", mem_addr, 32'h00007000);
    check("sw7_stall", 32'(stall), 32'h0);
    check("sw7_done", 32'(done), 32'h1);
    tick();
    access(1'b1, 32'h7000, 32'h123456AB, OP_B);
    check("sb7_wren", 32'(mem_wren), 32'h1);
    check("sb7_wdata", mem_wdata, 32'h123456AB);
    check("sb7_stall", 32'(stall), 32'h0);
    tick();
    idle();
    check("sb7_cnt", 32'(rmw_cnt), 32'h3);

    // Region boundaries
    access(1'b1, 32'h4000, 32'h00000011, OP_B);
    check("sb4000_stall", 32'(stall), 32'h0);
    check("sb4000_wren", 32'(mem_wren), 32'h1);
    tick();
    access(1'b1, 32'h3FFF, 32'h00000099, OP_B);
    check("sb3fff_stall", 32'(stall), 32'h1);
    tick();
    @(negedge clk);
    check("sb3fff_maddr", mem_addr, 32'h00003FFC);
    check("sb3fff_wdata", mem_wdata, 32'h99000000);
    tick();
    idle();
    check("sb3fff_cnt", 32'(rmw_cnt), 32'h4);

    // Misaligned accesses
    access(1'b0, 32'h2003, 32'h0, OP_H);
    check("lh3_mis", 32'(misal), 32'h1);
    check("lh3_wren", 32'(mem_wren), 32'h0);
    check("lh3_rdata", rdata, 32'h0);
    check("lh3_stall", 32'(stall), 32'h0);
    check("lh3_done", 32'(done), 32'h1);
    tick();
    access(1'b1, 32'h2006, 32'hCAFEF00D, OP_W);
    check("sw6_mis", 32'(misal), 32'h1);
    check("sw6_wren", 32'(mem_wren), 32'h0);
    check("sw6_stall", 32'(stall), 32'h0);
    tick();
    idle();
    @(negedge clk);
    check("mis_state", 32'(dbg_rmw), 32'h0);
    check("mis_cnt", 32'(rmw_cnt), 32'h4);
    check("idle_done", 32'(done), 32'h0);
    check("idle_mis", 32'(misal), 32'h0);
    check("idle_maddr", mem_addr, 32'h0);
    check("idle_wdata", mem_wdata, 32'h0);
    check("idle_rdata", rdata, 32'h0);
    tick();

    // Reset landing mid RMW_WR
    access(1'b1, 32'h2004, 32'h00000077, OP_B);
    tick();
    @(negedge clk);
    check("rstmid_wren_before", 32'(mem_wren), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_wren", 32'(mem_wren), 32'h0);
    check("rstmid_state", 32'(dbg_rmw), 32'h0);
    check("rstmid_cnt", 32'(rmw_cnt), 32'h0);
    check("rstmid_done", 32'(done), 32'h0);
    idle();
    #1 rst_n = 1'b1;
    tick();
    access(1'b0, 32'h2004, 32'h0, OP_W);
    check("rstmid_nowrite", rdata, 32'h11AB3344);
    tick();
    access(1'b1, 32'h2004, 32'h00000012, OP_B);
    check("post_c1_stall", 32'(stall), 32'h1);
    tick();
    @(negedge clk);
    check("post_c2_wdata", mem_wdata, 32'h11AB3312);
    tick();
    idle();
    check("post_cnt", 32'(rmw_cnt), 32'h1);
    access(1'b0, 32'h2004, 32'h0, OP_W);
    check("post_readback", rdata, 32'h11AB3312);
    tick();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
